// File: rtl/xy_lane_sched_pkg.sv
// Shared types for the xy_lane_sched scheduler slice.
package xy_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_GNT   = 2'b10,
        ST_TRUNC = 2'b11
    } lane_st_t;

    typedef logic [1:0] pri_t;

endpackage

// File: rtl/xy_lane_sched_if.sv
// Request/grant bundle between X requesting lanes and the scheduler.
// master = requesting side, slave = scheduler.
interface xy_lane_sched_if
    import xy_sched_pkg::*;
#(
    parameter int X = 4
) ();
    localparam int IW = $clog2(X);

    logic [X-1:0]       req;
    pri_t [X-1:0]       pri;
    logic [X-1:0]       done;
    logic [X-1:0]       gnt;
    logic [IW-1:0]      gnt_id;
    logic               busy;
    logic [X-1:0][1:0]  st;

    modport master (output req, pri, done, input gnt, gnt_id, busy, st);
    modport slave  (input req, pri, done, output gnt, gnt_id, busy, st);
endinterface

// File: rtl/xy_lane_sched_rr_pick.sv
// Round-robin picker: first eligible lane at index >= ptr, wrapping modulo X.
module xy_rr_pick #(
    parameter int X  = 4,
    parameter int IW = $clog2(X)
) (
    input  logic [X-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [X-1:0]  win_oh,
    output logic [IW-1:0] win_idx
);
    // Scan from ptr upward, first hit wins.
    always_comb begin
        int j;
        j       = 0;
        found   = 1'b0;
        win_oh  = '0;
        win_idx = '0;
        for (int k = 0; k < X; k++) begin
            j = (int'(ptr) + k) % X;
            if (!found && elig[j]) begin
                found     = 1'b1;
                win_oh[j] = 1'b1;
                win_idx   = IW'(j);
            end
        end
    end
endmodule

// File: rtl/xy_lane_sched.sv
// Priority-classed round-robin scheduler sharing one datapath slot among X lanes.
// Optional lane aging (starvation relief) enabled by XY_LANE_SCHED_AGING_EN.
module xy_lane_sched
    import xy_sched_pkg::*;
#(
    parameter int X         = 4,
    parameter int Y         = 1,
    parameter int BURST_MAX = 8,
    parameter int AGE_MAX   = 15
) (
    input  logic            clk,
    input  logic            rstb,
    xy_lane_sched_if.slave  bus
);
    localparam int IW = $clog2(X);
    localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam int GW = (Y > 1) ? $clog2(Y) : 1;

    sched_state_t      state;
    logic [IW-1:0]     ptr;
    logic [BW-1:0]     bcnt;
    logic [GW-1:0]     gcnt;
    logic              trunc;
    logic [X-1:0]      gnt;
    logic [IW-1:0]     gnt_id;
    logic              busy;
    logic [X-1:0][1:0] st;

    logic [X-1:0]      aged, elig, cls_m, win_oh;
    logic [IW-1:0]     win_idx;
    logic              found, own_req, own_done, burst_hit, release_c, trunc_c, arb_slot, take;

    // Eligible mask = requesters in the highest class present; aged lanes outrank all.
    always_comb begin
        elig  = '0;
        cls_m = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < X; i++) cls_m[i] = bus.req[i] && (bus.pri[i] == pri_t'(c));
            if (|cls_m) elig = cls_m;
        end
        if (|aged) elig = aged;
    end

    xy_rr_pick #(.X(X), .IW(IW)) u_pick (
        .elig    (elig),
        .ptr     (ptr),
        .found   (found),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    assign own_req   = bus.req[gnt_id];
    assign own_done  = bus.done[gnt_id];
    assign burst_hit = (bcnt == BW'(BURST_MAX - 1));
    assign release_c = own_done | ~own_req | burst_hit;
    // Only a pure burst-limit cut counts as truncation; done wins a tie.
    assign trunc_c   = burst_hit & ~own_done & own_req;
    assign arb_slot  = (state == IDLE) || (state == GAP && gcnt == GW'(Y - 1));
    assign take      = arb_slot & found;

    function automatic logic [X-1:0][1:0] st_vec(input logic [X-1:0] g, input logic tr,
                                                 input logic [IW-1:0] tl, input logic [X-1:0] r);
        logic [X-1:0][1:0] v;
        v = '0;
        for (int i = 0; i < X; i++) begin
            if (g[i])                             v[i] = ST_GNT;
            else if (tr && tl == IW'(i) && r[i])  v[i] = ST_TRUNC;
            else if (r[i])                        v[i] = ST_WAIT;
            else                                  v[i] = ST_IDLE;
        end
        return v;
    endfunction

    // Scheduler FSM; gnt/gnt_id/busy/st are registered alongside the state.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state  <= IDLE;
            ptr    <= '0;
            bcnt   <= '0;
            gcnt   <= '0;
            trunc  <= 1'b0;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            st     <= '0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (state == GAP && !arb_slot) begin
                        gcnt <= gcnt + 1'b1;
                        st   <= st_vec('0, trunc, gnt_id, bus.req);
                    end else if (found) begin
                        state  <= GRANT;
                        trunc  <= 1'b0;
                        gnt    <= win_oh;
                        gnt_id <= win_idx;
                        busy   <= 1'b1;
                        bcnt   <= '0;
                        st     <= st_vec(win_oh, 1'b0, win_idx, bus.req);
                    end else begin
                        state <= IDLE;
                        trunc <= 1'b0;
                        st    <= st_vec('0, 1'b0, gnt_id, bus.req);
                    end
                end
                GRANT: begin
                    if (release_c) begin
                        state <= GAP;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        gcnt  <= '0;
                        trunc <= trunc_c;
                        ptr   <= (gnt_id == IW'(X - 1)) ? '0 : gnt_id + 1'b1;
                        st    <= st_vec('0, trunc_c, gnt_id, bus.req);
                    end else begin
                        bcnt <= bcnt + 1'b1;
                        st   <= st_vec(gnt, 1'b0, gnt_id, bus.req);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef XY_LANE_SCHED_AGING_EN
    localparam int AW = $clog2(AGE_MAX + 1);
    logic [AW-1:0] age [X];

    // Per-lane wait age: counts while waiting, clears on grant or req drop.
    for (genvar i = 0; i < X; i++) begin : g_age
        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb)                                 age[i] <= '0;
            else if (!bus.req[i] || (take && win_oh[i])) age[i] <= '0;
            else if (!gnt[i] && age[i] != AW'(AGE_MAX)) age[i] <= age[i] + 1'b1;
        end
    end

    // A saturated waiting lane is promoted above every pri class.
    always_comb begin
        aged = '0;
        for (int i = 0; i < X; i++) aged[i] = bus.req[i] && (age[i] == AW'(AGE_MAX));
    end
`else
    // No aging: no lane is ever promoted, so strict priority applies.
    assign aged = {X{AGE_MAX < 0}};
`endif

    assign bus.gnt    = gnt;
    assign bus.gnt_id = gnt_id;
    assign bus.busy   = busy;
    assign bus.st     = st;
endmodule

// File: tb/tb_xy_lane_sched.sv
// Scoreboard bench for xy_lane_sched: a cycle model predicts every output of
// the main instance; directed checks cover the test-plan scenarios.
module tb_xy_lane_sched;
    import xy_sched_pkg::*;

    localparam int X = 4, Y = 1, BM = 8, AGE_MAX = 15;
`ifdef XY_LANE_SCHED_AGING_EN
    localparam bit AGING_ON = 1'b1;
`else
    localparam bit AGING_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    xy_lane_sched_if #(.X(X)) b1 ();
    xy_lane_sched_if #(.X(X)) b2 ();

    xy_lane_sched #(.X(X), .Y(Y), .BURST_MAX(BM), .AGE_MAX(AGE_MAX)) dut1 (
        .clk(clk), .rstb(rstb), .bus(b1));
    xy_lane_sched #(.X(X), .Y(3), .BURST_MAX(4), .AGE_MAX(AGE_MAX)) dut2 (
        .clk(clk), .rstb(rstb), .bus(b2));

    typedef struct {
        logic [X-1:0]      gnt;
        int                id;
        logic              busy;
        logic [X-1:0][1:0] st;
    } exp_t;

    exp_t q[$];
    int   log_q[$];
    int   checks = 0, errors = 0;

    // Reference model state: owner (-1 none), cycles held, gap cycles left.
    int m_own = -1, m_held = 0, m_gap = 0, m_ptr = 0, m_tl = 0;
    bit m_tr = 1'b0;
    int m_age[X];

    function automatic int lane_cls(int i, pri_t [X-1:0] p);
        return (AGING_ON && m_age[i] >= AGE_MAX) ? 4 : int'(p[i]);
    endfunction

    function automatic int pick(logic [X-1:0] r, pri_t [X-1:0] p);
        int best = -1;
        for (int i = 0; i < X; i++)
            if (r[i] && lane_cls(i, p) > best) best = lane_cls(i, p);
        if (best < 0) return -1;
        for (int k = 0; k < X; k++) begin
            int j = (m_ptr + k) % X;
            if (r[j] && lane_cls(j, p) == best) return j;
        end
        return -1;
    endfunction

    task automatic push_exp(logic [X-1:0] r);
        exp_t e;
        e.gnt  = (m_own >= 0) ? X'(1 << m_own) : '0;
        e.id   = (m_own >= 0) ? m_own : 0;
        e.busy = (m_own >= 0);
        for (int i = 0; i < X; i++) begin
            if (m_own == i)                                 e.st[i] = 2'b10;
            else if (m_gap > 0 && m_tr && m_tl == i && r[i]) e.st[i] = 2'b11;
            else                                            e.st[i] = r[i] ? 2'b01 : 2'b00;
        end
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_own = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_tl = 0; m_tr = 1'b0;
        for (int i = 0; i < X; i++) m_age[i] = 0;
        push_exp('0);
    endtask

    task automatic model_step();
        logic [X-1:0] r = b1.req;
        logic [X-1:0] d = b1.done;
        pri_t [X-1:0] p = b1.pri;
        int old = m_own;
        int w = -1;
        if (m_own >= 0) begin
            m_held++;
            if (d[m_own] || !r[m_own] || m_held == BM) begin
                m_tr  = (m_held == BM) && !d[m_own] && r[m_own];
                m_tl  = m_own;
                m_ptr = (m_own + 1) % X;
                m_own = -1;
                m_gap = Y;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) begin
                m_tr = 1'b0;
                w = pick(r, p);
            end
        end else begin
            w = pick(r, p);
        end
        if (w >= 0) begin
            m_own = w;
            m_held = 0;
        end
        for (int i = 0; i < X; i++) begin
            if (!r[i] || w == i)                   m_age[i] = 0;
            else if (i != old && m_age[i] < AGE_MAX) m_age[i]++;
        end
        push_exp(r);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstb) model_step();
        else      model_reset();
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
        end
    endtask

    task automatic do_reset();
        b1.req = '0; b1.done = '0; b1.pri = '0;
        b2.req = '0; b2.done = '0; b2.pri = '0;
        rstb = 1'b0;
        q.delete();
        tick();
        tick();
        rstb = 1'b1;
    endtask

    // Monitor: compare every cycle of dut1 against the model, log grant starts.
    exp_t       me;
    logic [X-1:0] prev_gnt = '0;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            checks++;
            if (b1.gnt !== me.gnt || b1.busy !== me.busy || b1.st !== me.st ||
                (me.busy && int'(b1.gnt_id) != me.id)) begin
                errors++;
                $display("FAIL model_cmp t=%0t gnt=%b/%b busy=%b/%b id=%0d/%0d st=%b/%b (actual/expected)",
                         $time, b1.gnt, me.gnt, b1.busy, me.busy, b1.gnt_id, me.id, b1.st, me.st);
            end
        end
        if (b1.gnt != '0 && b1.gnt != prev_gnt) log_q.push_back(int'(b1.gnt_id));
        prev_gnt = b1.gnt;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int exp2[5] = '{0, 1, 2, 3, 0};
        bit seen3;

        // Reset state
        do_reset();
        chk("rst_gnt", int'(b1.gnt), 0);
        chk("rst_busy", int'(b1.busy), 0);
        chk("rst_id", int'(b1.gnt_id), 0);
        chk("rst_st", int'(b1.st), 0);

        // Single lane: 1-cycle latency, 8-cycle burst, 1-cycle truncated gap
        b1.req = 4'b0001;
        tick();
        chk("t1_gnt", int'(b1.gnt), 1);
        chk("t1_id", int'(b1.gnt_id), 0);
        n = 0;
        while (b1.busy && n < 20) begin n++; tick(); end
        chk("t1_busy_len", n, 8);
        chk("t1_gap_gnt", int'(b1.gnt), 0);
        chk("t1_gap_st0", int'(b1.st[0]), 3);
        tick();
        chk("t1_regrant", int'(b1.gnt), 1);

        // All lanes, equal class, done on 2nd grant cycle
        do_reset();
        log_q.delete();
        b1.req = 4'b1111;
        n = 0;
        while (log_q.size() < 5 && n < 40) begin
            b1.done = (m_own >= 0 && m_held == 1) ? X'(1 << m_own) : '0;
            tick();
            n++;
        end
        b1.done = '0;
        for (int k = 0; k < 5; k++)
            chk("t2_order", (k < log_q.size()) ? log_q[k] : -1, exp2[k]);

        // Priority pick, then no preemption when pri changes mid-grant
        do_reset();
        log_q.delete();
        b1.pri[2] = 2'd3;
        b1.req = 4'b0110;
        tick();
        tick();
        b1.pri[1] = 2'd3;
        n = 0;
        while (log_q.size() < 2 && n < 40) begin tick(); n++; end
        chk("t3_first", (log_q.size() > 0) ? log_q[0] : -1, 2);
        chk("t3_second", (log_q.size() > 1) ? log_q[1] : -1, 1);

        // Y=3, BURST_MAX=4: done coincident with expiry, then pure expiry
        do_reset();
        b2.req = 4'b0001;
        tick();
        chk("t4_gnt", int'(b2.gnt), 1);
        repeat (3) tick();
        b2.done = 4'b0001;
        tick();
        b2.done = '0;
        for (int g = 0; g < 3; g++) begin
            chk("t4_gap_gnt", int'(b2.gnt), 0);
            chk("t4_gap_st0_not_trunc", int'(b2.st[0]), 1);
            tick();
        end
        chk("t4_regrant", int'(b2.gnt), 1);
        repeat (4) tick();
        for (int g = 0; g < 3; g++) begin
            chk("t4_trunc_gnt", int'(b2.gnt), 0);
            chk("t4_trunc_st0", int'(b2.st[0]), 3);
            tick();
        end
        chk("t4_regrant2", int'(b2.st[0]), 2);
        b2.req = '0;

        // Async reset mid-GRANT, restart from ptr=0
        do_reset();
        b1.req = 4'b1001;
        tick();
        b1.done = 4'b0001;
        tick();
        b1.done = '0;
        tick();
        chk("t5_lane3", int'(b1.gnt), 8);
        #2;
        rstb = 1'b0;
        q.delete();
        #1;
        chk("t5_async_gnt", int'(b1.gnt), 0);
        chk("t5_async_busy", int'(b1.busy), 0);
        chk("t5_async_st", int'(b1.st), 0);
        tick();
        rstb = 1'b1;
        tick();
        chk("t5_restart", int'(b1.gnt), 1);

        // Starvation: lane 3 low class vs three top-class lanes
        do_reset();
        log_q.delete();
        b1.pri = {2'd0, 2'd3, 2'd3, 2'd3};
        b1.req = 4'b1111;
        repeat (200) tick();
        seen3 = 1'b0;
        foreach (log_q[k]) if (log_q[k] == 3) seen3 = 1'b1;
        chk("t6_lane3_granted", int'(seen3), int'(AGING_ON));

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) b1.req = X'($urandom);
            if ($urandom_range(0, 7) == 0)
                for (int i = 0; i < X; i++) b1.pri[i] = pri_t'($urandom_range(0, 3));
            b1.done = ($urandom_range(0, 5) == 0) ? X'($urandom) : '0;
            tick();
        end
        b1.req = '0;
        b1.done = '0;
        repeat (4) tick();
        n = 0;
        while (q.size() > 0 && n < 10) begin @(negedge clk); n++; end
        chk("drain_queue", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xy_lane_sched.md
Name: xy_lane_sched

Overview:
- Round-robin, priority-classed scheduler that shares one xx/yy datapath slot among X requesting lanes.
- Per-lane 2-bit priority is packed [X-1:0][1:0], matching the xc vector layout.
- Issues a registered one-hot grant and enforces a burst limit plus a Y-cycle turnaround gap.
- Reports per-lane status in the same packed 2-bit-per-lane form as st.

Parameters:
- X, 4: number of requesting lanes (>=2).
- Y, 1: turnaround gap in cycles between consecutive grants (>=1).
- BURST_MAX, 8: maximum consecutive granted cycles per grant (>=1).
- AGE_MAX, 15: wait cycles before a lane is promoted (used only with the optional feature).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rstb  input  1  asynchronous active-low reset.
- req  input  X  per-lane request, level.
- pri  input  [X-1:0][1:0]  per-lane priority class; 3 is highest.
- done  input  X  owner asserts for one cycle to end its grant early.
- gnt  output  X  one-hot grant, registered.
- gnt_id  output  $clog2(X)  index of the current owner; valid while busy.
- busy  output  1  high while any gnt bit is high.
- st  output  [X-1:0][1:0]  per-lane status: 00 idle, 01 waiting, 10 granted, 11 truncated by burst limit.

Behaviour:
- Reset (async assert; deassert synchronous to clk):
  - gnt=0, gnt_id=0, busy=0, st=all 00.
  - rr pointer=0, burst counter=0, gap counter=0, state IDLE.
- FSM states: IDLE, GRANT, GAP.
- Arbitration:
  - Sample req and pri at arbitration time.
  - Select the highest pri class present among requesting lanes.
  - Within that class, pick the first requesting lane at index >= ptr, wrapping modulo X.
- IDLE: if any req, arbitrate. The next cycle enters GRANT with gnt/gnt_id/busy asserted (1-cycle req->gnt latency) and burst counter=0.
- GRANT:
  - Burst counter increments every cycle.
  - Release when done[owner]=1, or req[owner]=0, or counter==BURST_MAX-1.
  - Release takes effect the next cycle: gnt=0, enter GAP, ptr=(owner+1) mod X.
  - Coincident done and burst expiry produce a single release; st shows 10->00/01, not 11.
- GAP:
  - Holds gnt=0 for exactly Y cycles.
  - Arbitration happens in the last GAP cycle. The next cycle is GRANT if any req is high, else IDLE.
  - Minimum grant-to-grant spacing is therefore Y idle cycles.
- BURST_MAX=1: every grant lasts exactly one cycle.
- st per lane, registered and cycle-aligned with gnt:
  - 10 while granted.
  - 11 for the GAP cycles following a burst-limit release, when req is still high.
  - Otherwise 01 if req is high, else 00.
- Changes to pri or other lanes' req during GRANT never preempt the owner.
- req dropping on a non-owner removes it from the next arbitration.
- ptr advances only on release, never in IDLE.
- Reset asserted mid-GRANT clears gnt immediately (async). No release pulse is generated.

Optional Feature:
- Macro: XY_LANE_SCHED_AGING_EN.
- With the macro:
  - Each lane has an age counter that counts up when the lane is waiting (req=1, not owner) and saturates at AGE_MAX.
  - A lane whose counter is saturated is treated as class 4, above all pri values. Aged lanes are ordered among themselves round-robin.
  - A lane's counter clears on its grant or when its req drops.
- Without the macro: no age counters exist; strict priority applies and low classes may starve.

Decomposition:
- Package xy_sched_pkg:
  - sched_state_t enum (IDLE, GRANT, GAP).
  - lane_st_t 2-bit enum (ST_IDLE, ST_WAIT, ST_GNT, ST_TRUNC).
  - pri_t = logic [1:0].
- Sub-module xy_rr_pick: combinational. Inputs are an eligible mask and ptr; outputs are found and a one-hot winner with its index. It is instantiated once and fed the highest-class mask.

Test Plan:
- req=4'b0001 rising after reset -> gnt=4'b0001, gnt_id=0 one cycle later; busy holds for 8 cycles; then gnt=0 for 1 cycle; st[0]=11 during the gap.
- req=4'b1111 held, all pri=0, done pulsed on every 2nd grant cycle -> grants in order 0,1,2,3,0, each 2 cycles long, with 1 idle cycle between grants.
- req=4'b0110, pri[1]=0, pri[2]=3 -> lane 2 granted first. pri[1] raised to 3 mid-grant -> no preemption; lane 1 is granted after the gap.
- Y=3, lane 0 grant; done and burst expiry asserted in the same cycle -> single release, exactly 3 gap cycles, st[0] never 11.
- rstb pulled low mid-GRANT -> gnt, busy and st go to 0 asynchronously; after release, lane 0 wins with ptr=0.
- Aging on, AGE_MAX=15, lane 3 pri=0 and lanes 0-2 pri=3 continuously requesting -> lane 3 is granted after its age counter saturates. Aging off -> lane 3 is never granted within 200 cycles.
